unified_mem_arb: RTL and testbench
==================================

# unified_mem_arb

Multi-cycle arbiter that shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch port (IF) and data-memory stage (DM). Each request runs through a four-state FSM with a latency counter. The arbiter presents per-port done pulses and stall lines to the pipeline hazard logic, which folds them into `stall_n`. A fetch abort discards wrong-path fetches after a taken branch.

## Interface
- `ADDR_W`, 16: address width
- `DATA_W`, 16: data width
- `MEM_LAT`, 4: cycles from the memory issue cycle to the cycle `mem_rdata` is valid; must be ≥ 1

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  fetch request, level, held until `if_done`
- `if_abort`  in  1  cancel the outstanding or current fetch (branch taken)
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched word
- `if_done`  out  1  one-cycle completion pulse
- `if_stall`  out  1  `if_req & ~if_done`
- `dm_req`  in  1  data request, level, held until `dm_done`
- `dm_wr`  in  1  1 = write, 0 = read
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_rdata`  out  DATA_W  load data
- `dm_done`  out  1  one-cycle completion pulse
- `dm_stall`  out  1  `dm_req & ~dm_done`
- `mem_en`  out  1  memory issue strobe
- `mem_wr`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE. An owner register holds IF or DM.
- IDLE arbitrates with fixed priority, DM over IF, because DM is the older instruction.
  - Grant DM if `dm_req`.
  - Otherwise grant IF if `if_req & ~if_abort`.
  - On a grant, latch owner, address, write flag and write data, then go to ISSUE.
  - With no grant, stay in IDLE.
- ISSUE lasts one cycle. `mem_en=1`, and `mem_wr`, `mem_addr` and `mem_wdata` come from the latched values. The counter loads `MEM_LAT-1`, then the FSM goes to WAIT.
- WAIT decrements the counter each cycle. When the counter is 0, the arbiter captures `mem_rdata` into the owner's rdata register (reads only) and goes to DONE.
- DONE lasts one cycle and pulses the owner's done, then goes to IDLE.
  - No arbitration happens in DONE. A req seen in the following IDLE is a new request.
- Abort:
  - `if_abort` in any non-IDLE cycle while owner is IF sets an abort flag.
  - The memory access still completes, but `if_rdata` is not updated and `if_done` is suppressed in DONE.
  - The flag clears on entry to IDLE.
  - `if_abort` while owner is DM is ignored.
- `if_rdata` and `dm_rdata` hold their last value until the next non-aborted read by the same port. Writes leave `dm_rdata` unchanged.
- The counter width is `$clog2(MEM_LAT)+1`. The counter never wraps below 0.

## Timing
- Reset values: state IDLE and all outputs 0 (`mem_*`, done, stall, rdata). Counter, owner and abort flag are also 0.
- Reset asserted mid-operation: the FSM returns to IDLE immediately. The in-flight access is abandoned and no done pulse is produced.
- A grant registered at the end of cycle t gives:
  - `mem_en` in cycle t+1
  - data valid at t+1+`MEM_LAT`
  - done in cycle t+2+`MEM_LAT`
  - rdata valid from the done cycle onward
- Throughput is one access per `MEM_LAT`+3 cycles, because of the IDLE bubble between accesses.
- All `mem_*` outputs are registered. `mem_en` is high for exactly one cycle per access.
- Requesters hold address and data stable while stalled. The arbiter ignores input changes after the grant.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/DONE)
  - the owner enum (OWN_IF/OWN_DM)
  - the default `MEM_LAT` constant
- Sub-module `mem_lat_counter` is a loadable down-counter with a zero flag, parameterized by `MEM_LAT`.

## Test plan
All scenarios use `MEM_LAT`=4, and cycle 0 is the first cycle after reset release.
1. `if_req`=1 with `if_addr`=0x0010 in cycle 0, and `mem_rdata`=0xA5A5 in cycle 5 → `mem_en`=1, `mem_wr`=0, `mem_addr`=0x0010 in cycle 1 only. `if_done`=1 in cycle 6 with `if_rdata`=0xA5A5, and `if_stall`=1 in cycles 0–5.
2. Both requests in cycle 0, with DM writing 0x1234 to 0x0100 → cycle 1: `mem_en`=1, `mem_wr`=1, `mem_addr`=0x0100, `mem_wdata`=0x1234. `dm_done` in cycle 6, IF issued in cycle 8, `if_done` in cycle 13, and `dm_rdata` unchanged.
3. IF granted in cycle 0, `if_abort` pulsed in cycle 3 → the access completes, there is no `if_done` in cycle 6, `if_rdata` keeps its old value, and the FSM is in IDLE in cycle 7.
4. DM read in progress, `rst_n` low in cycle 3 → all outputs are 0 immediately and there is no `dm_done`. After release, a new `dm_req` is served with done 6 cycles later.
5. `dm_req` held through `dm_done` (cycle 6) with a new address 0x0200 → a second `mem_en` in cycle 8 with `mem_addr`=0x0200, and `dm_done` in cycle 13.
6. With `MEM_LAT`=1, an IF read in cycle 0 → `mem_en` in cycle 1, data sampled in cycle 2, and `if_done` in cycle 3.

Source files
------------

// File: rtl/unified_mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states, port ownership
// and the default memory latency.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } arb_state_e;

   typedef enum logic {
      OWN_IF,
      OWN_DM
   } owner_e;

   localparam int MEM_LAT_DEFAULT = 4;

endpackage

// File: rtl/unified_mem_arb_if.sv
// Bundle of the fetch port, data port and memory port of the unified arbiter.
// The arbiter is the slave side; the pipeline/memory environment is the master.
interface unified_mem_arb_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) ();

   logic              if_req;
   logic              if_abort;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;
   logic              if_stall;

   logic              dm_req;
   logic              dm_wr;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_done;
   logic              dm_stall;

   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_abort, if_addr,
      input  dm_req, dm_wr, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_rdata, if_done, if_stall,
      output dm_rdata, dm_done, dm_stall,
      output mem_en, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_abort, if_addr,
      output dm_req, dm_wr, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_rdata, if_done, if_stall,
      input  dm_rdata, dm_done, dm_stall,
      input  mem_en, mem_wr, mem_addr, mem_wdata
   );

endinterface

// File: rtl/unified_mem_arb_lat_counter.sv
// Loadable down-counter that times the fixed memory latency; saturates at zero.
module mem_lat_counter #(
   parameter int MEM_LAT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int CNT_W = $clog2(MEM_LAT) + 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/unified_mem_arb.sv
// Shares one fixed-latency single-ported memory between instruction fetch and
// the data-memory stage; data side wins because it is the older instruction.
module unified_mem_arb
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
   input logic              clk,
   input logic              rst_n,
   unified_mem_arb_if.slave bus
);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   logic              abort_q, abort_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_wr_q, mem_wr_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_done_q, if_done_d;
   logic              dm_done_q, dm_done_d;
   logic              cnt_load, cnt_dec, cnt_zero;

   mem_lat_counter #(
      .MEM_LAT (MEM_LAT)
   ) u_lat_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cnt_load),
      .dec   (cnt_dec),
      .zero  (cnt_zero)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      abort_d    = abort_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mem_en_d   = 1'b0;
      mem_wr_d   = 1'b0;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if_done_d  = 1'b0;
      dm_done_d  = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;

      // A branch can kill a fetch at any point after grant; the access itself still runs out.
      if ((state_q != IDLE) && (owner_q == OWN_IF) && bus.if_abort) begin
         abort_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (bus.dm_req) begin
               owner_d  = OWN_DM;
               addr_d   = bus.dm_addr;
               wr_d     = bus.dm_wr;
               wdata_d  = bus.dm_wdata;
               mem_en_d = 1'b1;
               mem_wr_d = bus.dm_wr;
               state_d  = ISSUE;
            end else if (bus.if_req && !bus.if_abort) begin
               owner_d  = OWN_IF;
               addr_d   = bus.if_addr;
               wr_d     = 1'b0;
               wdata_d  = '0;
               mem_en_d = 1'b1;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            cnt_load = 1'b1;
            state_d  = WAIT;
         end
         WAIT: begin
            if (cnt_zero) begin
               state_d = DONE;
               if (owner_q == OWN_DM) begin
                  if (!wr_q) dm_rdata_d = bus.mem_rdata;
                  dm_done_d = 1'b1;
               end else if (!(abort_q || bus.if_abort)) begin
                  if_rdata_d = bus.mem_rdata;
                  if_done_d  = 1'b1;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         DONE: begin
            abort_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         abort_q    <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mem_en_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         if_done_q  <= 1'b0;
         dm_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         abort_q    <= abort_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         mem_en_q   <= mem_en_d;
         mem_wr_q   <= mem_wr_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         if_done_q  <= if_done_d;
         dm_done_q  <= dm_done_d;
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.dm_done   = dm_done_q;
   // Stalls are forced low while in reset so every output reads 0 there.
   assign bus.if_stall  = rst_n & bus.if_req & ~if_done_q;
   assign bus.dm_stall  = rst_n & bus.dm_req & ~dm_done_q;

endmodule

// File: tb/tb_unified_mem_arb.sv
// Directed-vector bench for unified_mem_arb: one MEM_LAT=4 instance for the
// main scenarios and one MEM_LAT=1 instance for the minimum-latency case.
module tb_unified_mem_arb;
   import mem_arb_pkg::*;

   logic clk;
   logic rst_n;
   int   errs;
   int   checks;

   unified_mem_arb_if #(.ADDR_W(16), .DATA_W(16)) ba ();
   unified_mem_arb_if #(.ADDR_W(16), .DATA_W(16)) bb ();

   unified_mem_arb #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ba)
   );

   unified_mem_arb #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      ba.if_req = 0; ba.if_abort = 0; ba.if_addr = '0;
      ba.dm_req = 0; ba.dm_wr = 0; ba.dm_addr = '0; ba.dm_wdata = '0;
      ba.mem_rdata = '0;
      bb.if_req = 0; bb.if_abort = 0; bb.if_addr = '0;
      bb.dm_req = 0; bb.dm_wr = 0; bb.dm_addr = '0; bb.dm_wdata = '0;
      bb.mem_rdata = '0;
   endtask

   // Leaves the bench 1 time unit into cycle 0 (first cycle after release).
   task automatic apply_reset();
      rst_n = 0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      ba.if_req = 1; ba.dm_req = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (ba.mem_en !== 1'b0) begin errs++; $display("FAIL rst_mem_en got=%b exp=0", ba.mem_en); end
      checks++; if (ba.mem_wr !== 1'b0) begin errs++; $display("FAIL rst_mem_wr got=%b exp=0", ba.mem_wr); end
      checks++; if (ba.mem_addr !== 16'h0) begin errs++; $display("FAIL rst_mem_addr got=%h exp=0000", ba.mem_addr); end
      checks++; if (ba.mem_wdata !== 16'h0) begin errs++; $display("FAIL rst_mem_wdata got=%h exp=0000", ba.mem_wdata); end
      checks++; if (ba.if_done !== 1'b0 || ba.dm_done !== 1'b0) begin errs++; $display("FAIL rst_done got=%b%b exp=00", ba.if_done, ba.dm_done); end
      checks++; if (ba.if_stall !== 1'b0 || ba.dm_stall !== 1'b0) begin errs++; $display("FAIL rst_stall got=%b%b exp=00", ba.if_stall, ba.dm_stall); end
      checks++; if (ba.if_rdata !== 16'h0 || ba.dm_rdata !== 16'h0) begin errs++; $display("FAIL rst_rdata got=%h/%h exp=0000/0000", ba.if_rdata, ba.dm_rdata); end
      checks++; if (dut_a.state_q !== IDLE) begin errs++; $display("FAIL rst_state got=%0d exp=%0d", dut_a.state_q, IDLE); end
      checks++; if (bb.mem_en !== 1'b0 || bb.if_done !== 1'b0) begin errs++; $display("FAIL rst_b_out got=%b%b exp=00", bb.mem_en, bb.if_done); end
   endtask

   task automatic test_if_read();
      apply_reset();
      for (int c = 0; c <= 7; c++) begin
         ba.if_req    = (c <= 6);
         ba.if_addr   = 16'h0010;
         ba.mem_rdata = (c == 5) ? 16'hA5A5 : 16'hDEAD;
         @(negedge clk);
         checks++; if (ba.mem_en !== (c == 1)) begin errs++; $display("FAIL t1_mem_en cyc=%0d got=%b exp=%b", c, ba.mem_en, (c == 1)); end
         if (c == 1) begin
            checks++; if (ba.mem_wr !== 1'b0 || ba.mem_addr !== 16'h0010) begin errs++; $display("FAIL t1_issue wr/addr got=%b/%h exp=0/0010", ba.mem_wr, ba.mem_addr); end
         end
         checks++; if (ba.if_done !== (c == 6)) begin errs++; $display("FAIL t1_if_done cyc=%0d got=%b exp=%b", c, ba.if_done, (c == 6)); end
         checks++; if (ba.if_stall !== (c <= 5)) begin errs++; $display("FAIL t1_if_stall cyc=%0d got=%b exp=%b", c, ba.if_stall, (c <= 5)); end
         if (c == 6) begin
            checks++; if (ba.if_rdata !== 16'hA5A5) begin errs++; $display("FAIL t1_if_rdata got=%h exp=a5a5", ba.if_rdata); end
         end
         tick();
      end
   endtask

   task automatic test_priority_write();
      apply_reset();
      for (int c = 0; c <= 14; c++) begin
         ba.dm_req    = (c <= 6);
         ba.dm_wr     = 1;
         ba.dm_addr   = 16'h0100;
         ba.dm_wdata  = 16'h1234;
         ba.if_req    = (c <= 13);
         ba.if_addr   = 16'h0020;
         ba.mem_rdata = 16'h5555;
         @(negedge clk);
         checks++; if (ba.mem_en !== (c == 1 || c == 8)) begin errs++; $display("FAIL t2_mem_en cyc=%0d got=%b exp=%b", c, ba.mem_en, (c == 1 || c == 8)); end
         if (c == 1) begin
            checks++; if (ba.mem_wr !== 1'b1 || ba.mem_addr !== 16'h0100 || ba.mem_wdata !== 16'h1234) begin
               errs++; $display("FAIL t2_dm_issue wr/addr/wdata got=%b/%h/%h exp=1/0100/1234", ba.mem_wr, ba.mem_addr, ba.mem_wdata);
            end
         end
         if (c == 8) begin
            checks++; if (ba.mem_wr !== 1'b0 || ba.mem_addr !== 16'h0020) begin errs++; $display("FAIL t2_if_issue wr/addr got=%b/%h exp=0/0020", ba.mem_wr, ba.mem_addr); end
         end
         checks++; if (ba.dm_done !== (c == 6)) begin errs++; $display("FAIL t2_dm_done cyc=%0d got=%b exp=%b", c, ba.dm_done, (c == 6)); end
         checks++; if (ba.if_done !== (c == 13)) begin errs++; $display("FAIL t2_if_done cyc=%0d got=%b exp=%b", c, ba.if_done, (c == 13)); end
         checks++; if (ba.dm_rdata !== 16'h0000) begin errs++; $display("FAIL t2_dm_rdata cyc=%0d got=%h exp=0000", c, ba.dm_rdata); end
         if (c == 13) begin
            checks++; if (ba.if_rdata !== 16'h5555) begin errs++; $display("FAIL t2_if_rdata got=%h exp=5555", ba.if_rdata); end
         end
         tick();
      end
   endtask

   task automatic test_abort();
      apply_reset();
      for (int c = 0; c <= 8; c++) begin
         ba.if_req    = (c <= 2);
         ba.if_abort  = (c == 3);
         ba.if_addr   = 16'h0030;
         ba.mem_rdata = 16'h7777;
         @(negedge clk);
         checks++; if (ba.mem_en !== (c == 1)) begin errs++; $display("FAIL t3_mem_en cyc=%0d got=%b exp=%b", c, ba.mem_en, (c == 1)); end
         checks++; if (ba.if_done !== 1'b0) begin errs++; $display("FAIL t3_if_done cyc=%0d got=%b exp=0", c, ba.if_done); end
         if (c == 6 || c == 8) begin
            checks++; if (ba.if_rdata !== 16'h0000) begin errs++; $display("FAIL t3_if_rdata cyc=%0d got=%h exp=0000", c, ba.if_rdata); end
         end
         if (c == 5) begin
            checks++; if (dut_a.state_q !== WAIT) begin errs++; $display("FAIL t3_state_wait got=%0d exp=%0d", dut_a.state_q, WAIT); end
         end
         if (c == 7) begin
            checks++; if (dut_a.state_q !== IDLE) begin errs++; $display("FAIL t3_state_idle got=%0d exp=%0d", dut_a.state_q, IDLE); end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int c = 0; c <= 2; c++) begin
         ba.dm_req    = 1;
         ba.dm_wr     = 0;
         ba.dm_addr   = 16'h0300;
         ba.mem_rdata = 16'h9999;
         @(negedge clk);
         if (c == 1) begin
            checks++; if (ba.mem_en !== 1'b1 || ba.mem_addr !== 16'h0300) begin errs++; $display("FAIL t4_issue en/addr got=%b/%h exp=1/0300", ba.mem_en, ba.mem_addr); end
         end
         tick();
      end
      rst_n = 0;
      #1;
      checks++; if (ba.mem_en !== 1'b0 || ba.mem_wr !== 1'b0 || ba.mem_addr !== 16'h0 || ba.mem_wdata !== 16'h0) begin
         errs++; $display("FAIL t4_mem_zero en/wr/addr/wdata got=%b/%b/%h/%h exp=0/0/0000/0000", ba.mem_en, ba.mem_wr, ba.mem_addr, ba.mem_wdata);
      end
      checks++; if (ba.dm_done !== 1'b0 || ba.dm_stall !== 1'b0 || ba.dm_rdata !== 16'h0) begin
         errs++; $display("FAIL t4_dm_zero done/stall/rdata got=%b/%b/%h exp=0/0/0000", ba.dm_done, ba.dm_stall, ba.dm_rdata);
      end
      checks++; if (dut_a.state_q !== IDLE) begin errs++; $display("FAIL t4_state got=%0d exp=%0d", dut_a.state_q, IDLE); end
      ba.dm_req = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++; if (ba.dm_done !== 1'b0) begin errs++; $display("FAIL t4_no_done k=%0d got=%b exp=0", k, ba.dm_done); end
      end
      @(posedge clk);
      #1 rst_n = 1;
      for (int c = 0; c <= 7; c++) begin
         ba.dm_req    = (c <= 6);
         ba.dm_addr   = 16'h0304;
         ba.mem_rdata = (c == 5) ? 16'h4242 : 16'h9999;
         @(negedge clk);
         checks++; if (ba.dm_done !== (c == 6)) begin errs++; $display("FAIL t4_dm_done cyc=%0d got=%b exp=%b", c, ba.dm_done, (c == 6)); end
         if (c == 6) begin
            checks++; if (ba.dm_rdata !== 16'h4242) begin errs++; $display("FAIL t4_dm_rdata got=%h exp=4242", ba.dm_rdata); end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int c = 0; c <= 14; c++) begin
         ba.dm_req    = (c <= 13);
         ba.dm_wr     = 0;
         ba.dm_addr   = (c <= 5) ? 16'h0100 : 16'h0200;
         ba.mem_rdata = (c == 5) ? 16'h1111 : ((c == 12) ? 16'h2222 : 16'h0000);
         @(negedge clk);
         checks++; if (ba.mem_en !== (c == 1 || c == 8)) begin errs++; $display("FAIL t5_mem_en cyc=%0d got=%b exp=%b", c, ba.mem_en, (c == 1 || c == 8)); end
         if (c == 1) begin
            checks++; if (ba.mem_addr !== 16'h0100) begin errs++; $display("FAIL t5_addr1 got=%h exp=0100", ba.mem_addr); end
         end
         if (c == 8) begin
            checks++; if (ba.mem_addr !== 16'h0200) begin errs++; $display("FAIL t5_addr2 got=%h exp=0200", ba.mem_addr); end
         end
         checks++; if (ba.dm_done !== (c == 6 || c == 13)) begin errs++; $display("FAIL t5_dm_done cyc=%0d got=%b exp=%b", c, ba.dm_done, (c == 6 || c == 13)); end
         if (c == 6) begin
            checks++; if (ba.dm_rdata !== 16'h1111) begin errs++; $display("FAIL t5_rdata1 got=%h exp=1111", ba.dm_rdata); end
         end
         if (c == 13) begin
            checks++; if (ba.dm_rdata !== 16'h2222) begin errs++; $display("FAIL t5_rdata2 got=%h exp=2222", ba.dm_rdata); end
         end
         tick();
      end
   endtask

   task automatic test_lat1();
      apply_reset();
      for (int c = 0; c <= 5; c++) begin
         bb.if_req    = (c <= 3);
         bb.if_addr   = 16'h0040;
         bb.mem_rdata = (c == 2) ? 16'hBEEF : 16'h0000;
         @(negedge clk);
         checks++; if (bb.mem_en !== (c == 1)) begin errs++; $display("FAIL t6_mem_en cyc=%0d got=%b exp=%b", c, bb.mem_en, (c == 1)); end
         if (c == 1) begin
            checks++; if (bb.mem_addr !== 16'h0040) begin errs++; $display("FAIL t6_addr got=%h exp=0040", bb.mem_addr); end
         end
         checks++; if (bb.if_done !== (c == 3)) begin errs++; $display("FAIL t6_if_done cyc=%0d got=%b exp=%b", c, bb.if_done, (c == 3)); end
         if (c == 3) begin
            checks++; if (bb.if_rdata !== 16'hBEEF) begin errs++; $display("FAIL t6_if_rdata got=%h exp=beef", bb.if_rdata); end
         end
         tick();
      end
   endtask

   initial begin
      errs   = 0;
      checks = 0;
      rst_n  = 0;
      idle_inputs();
      test_reset();
      test_if_read();
      test_priority_write();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_lat1();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
